gshare_ongorucu_param: RTL and testbench
========================================

// Module: gshare_ongorucu_param
// PURPOSE
//  Parametrised gshare branch predictor with decoupled predict and resolve ports.
//  Fetch stage sends branch PCs; the predictor returns a registered taken/not-taken guess.
//  A pending queue records each prediction's table index and guess until the branch resolves in order.
//  On resolve it trains a saturating counter, shifts global history, flags mispredicts and flushes younger entries.
// PARAMETERS
//  IDX_W       5  table index width; table depth = 2**IDX_W counters
//  HIST_W      5  global history width, 1..IDX_W
//  CTR_W       2  saturating counter width, >=2
//  PC_LSB      2  lowest PC bit used for indexing
//  PEND_DEPTH  4  pending-branch queue depth, power of 2, >=2
// PORTS
//  i_saat            in   1           clock, rising edge
//  i_reset           in   1           synchronous, active-high reset
//  i_tahmin_gecerli  in   1           predict request valid
//  i_buyruk_sayaci   in   32          PC of branch to predict
//  o_istek_hazir     out  1           queue not full; request accepted iff valid & hazir
//  o_tahmin_hazir    out  1           prediction valid, 1 cycle after accepted request
//  o_buyruk_ongoru   out  1           predicted direction, 1 = taken
//  i_sonuc_gecerli   in   1           resolve valid; refers to oldest pending branch
//  i_buyruk_atladi   in   1           actual direction of resolving branch
//  o_ongoru_yanlis   out  1           mispredict pulse, 1 cycle after resolve
//  o_bos_cozum       out  1           sticky: resolve arrived with empty queue
//  o_gecmis          out  HIST_W      committed global history
//  o_bekleyen        out  $clog2(PEND_DEPTH)+1  pending entry count
// BEHAVIOUR
//  Reset (i_reset=1 at clock edge):
//   - every counter = 2**(CTR_W-1)-1 (weak not-taken)
//   - history = 0; queue empty
//   - all outputs 0, except o_istek_hazir = 1
//   - reset overrides any same-cycle request or resolve
//  Index = PC[PC_LSB+IDX_W-1:PC_LSB] ^ {zero-pad, history}; uses committed history at request cycle.
//  Predict:
//   - on accept, read ctr[idx]; the counter MSB becomes o_buyruk_ongoru next cycle, with o_tahmin_hazir=1
//   - push {idx, guess} onto the queue
//   - o_buyruk_ongoru holds its last value when o_tahmin_hazir=0
//  Resolve (i_sonuc_gecerli=1, queue not empty):
//   - pop head; ctr[head.idx] +1 if taken, -1 if not, saturating at 0 and 2**CTR_W-1
//   - history <= {history[HIST_W-2:0], taken}; o_ongoru_yanlis <= (head.guess != taken)
//  Mispredict flush:
//   - when the popped entry mispredicts, the whole queue is cleared (count=0); younger branches are on the wrong path
//   - a request accepted in that same cycle is discarded: no push, and o_tahmin_hazir=0 next cycle
//  Resolve with empty queue: no table or history change, o_ongoru_yanlis=0, o_bos_cozum set until reset.
//  Simultaneous push and correct pop: count unchanged; the queue pointers wrap modulo PEND_DEPTH.
//  o_istek_hazir = (count != PEND_DEPTH), from registered state only; a pop in the same cycle does not free a slot for a full-queue push.
//  Read-during-update of the same index: prediction uses the pre-update counter value.
//  Index and history are both computed from pre-update state.
//  History is non-speculative; it changes only on resolve.
// TESTING
//  1. Reset, then predict PC=0x40 -> o_tahmin_hazir=1 next cycle, o_buyruk_ongoru=0, o_bekleyen=1.
//  2. Four predict+resolve(taken) pairs, same PC, history forced equal -> counter reaches 3 and saturates; next guess=1.
//  3. Predict 4 branches with no resolve -> o_istek_hazir=0; a 5th request is ignored; o_bekleyen=4.
//  4. With 3 pending, head guess=0, resolve taken=1 -> o_ongoru_yanlis pulses 1 cycle, o_bekleyen=0, history LSB=1.
//  5. Resolve with an empty queue -> o_bos_cozum=1 sticky, o_gecmis unchanged, o_ongoru_yanlis=0.
//  6. Assert i_reset while 2 branches are pending and a request is active -> counters weak-NT, o_bekleyen=0, no o_tahmin_hazir.

Source files
------------

// File: rtl/gshare_ongorucu_param.sv
// Parametrised gshare branch predictor with decoupled predict and in-order resolve ports.
// A small pending queue remembers each prediction's table index and guess until it resolves.
module gshare_ongorucu_param #(
    parameter int IDX_W      = 5,
    parameter int HIST_W     = 5,
    parameter int CTR_W      = 2,
    parameter int PC_LSB     = 2,
    parameter int PEND_DEPTH = 4
) (
    input  logic                          i_saat,
    input  logic                          i_reset,
    input  logic                          i_tahmin_gecerli,
    input  logic [31:0]                   i_buyruk_sayaci,
    output logic                          o_istek_hazir,
    output logic                          o_tahmin_hazir,
    output logic                          o_buyruk_ongoru,
    input  logic                          i_sonuc_gecerli,
    input  logic                          i_buyruk_atladi,
    output logic                          o_ongoru_yanlis,
    output logic                          o_bos_cozum,
    output logic [HIST_W-1:0]             o_gecmis,
    output logic [$clog2(PEND_DEPTH):0]   o_bekleyen
);

    localparam int PTR_W = $clog2(PEND_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TBL_D = 2 ** IDX_W;

    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(PEND_DEPTH);
    localparam logic [CNT_W-1:0] CNT_EMPTY = '0;
    localparam logic [CTR_W-1:0] CTR_MAX   = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0] CTR_MIN   = '0;
    localparam logic [CTR_W-1:0] CTR_INIT  = CTR_MAX >> 1;
    localparam logic [31:0]      PC_MASK   = ((32'(1) << IDX_W) - 32'(1)) << PC_LSB;

    // Pattern history table and pending-branch queue
    logic [CTR_W-1:0] ctr_q        [TBL_D];
    logic [IDX_W-1:0] pend_idx_q   [PEND_DEPTH];
    logic             pend_guess_q [PEND_DEPTH];

    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [HIST_W-1:0] hist_q, hist_d;
    logic              hazir_q, hazir_d;
    logic              ongoru_q, ongoru_d;
    logic              yanlis_q, yanlis_d;
    logic              bos_q, bos_d;

    logic             istek_hazir;
    logic             accept;
    logic             push;
    logic             pop;
    logic             mispredict;
    logic [IDX_W-1:0] req_idx;
    logic             req_guess;
    logic [IDX_W-1:0] head_idx;
    logic             head_guess;
    logic [CTR_W-1:0] ctr_old;
    logic [CTR_W-1:0] ctr_new;
    logic             unused_pc;

    // Readiness depends on registered occupancy only, so a same-cycle pop never admits a push into a full queue.
    assign istek_hazir = (cnt_q != CNT_FULL);
    assign accept      = i_tahmin_gecerli & istek_hazir;

    assign req_idx   = i_buyruk_sayaci[PC_LSB +: IDX_W] ^ IDX_W'(hist_q);
    assign req_guess = ctr_q[req_idx][CTR_W-1];
    assign unused_pc = ^(i_buyruk_sayaci & ~PC_MASK);

    assign head_idx   = pend_idx_q[head_q];
    assign head_guess = pend_guess_q[head_q];
    assign ctr_old    = ctr_q[head_idx];

    assign pop        = i_sonuc_gecerli & (cnt_q != CNT_EMPTY);
    assign mispredict = pop & (head_guess != i_buyruk_atladi);
    assign push       = accept & ~mispredict;

    always_comb begin
        ctr_new = ctr_old;
        if (i_buyruk_atladi) begin
            if (ctr_old != CTR_MAX) begin
                ctr_new = ctr_old + CTR_W'(1);
            end
        end else begin
            if (ctr_old != CTR_MIN) begin
                ctr_new = ctr_old - CTR_W'(1);
            end
        end
    end

    always_comb begin
        head_d   = head_q;
        tail_d   = tail_q;
        cnt_d    = cnt_q;
        hist_d   = hist_q;
        hazir_d  = push;
        ongoru_d = ongoru_q;
        yanlis_d = mispredict;
        bos_d    = bos_q | (i_sonuc_gecerli & (cnt_q == CNT_EMPTY));

        if (push) begin
            ongoru_d = req_guess;
        end

        if (pop) begin
            hist_d = HIST_W'({hist_q, i_buyruk_atladi});
        end

        // Younger entries were fetched down the wrong path, so a mispredict empties the queue.
        if (mispredict) begin
            head_d = '0;
            tail_d = '0;
            cnt_d  = CNT_EMPTY;
        end else begin
            if (pop) begin
                head_d = head_q + PTR_W'(1);
            end
            if (push) begin
                tail_d = tail_q + PTR_W'(1);
            end
            if (push && !pop) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else if (pop && !push) begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_saat) begin
        if (i_reset) begin
            head_q   <= '0;
            tail_q   <= '0;
            cnt_q    <= CNT_EMPTY;
            hist_q   <= '0;
            hazir_q  <= 1'b0;
            ongoru_q <= 1'b0;
            yanlis_q <= 1'b0;
            bos_q    <= 1'b0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            cnt_q    <= cnt_d;
            hist_q   <= hist_d;
            hazir_q  <= hazir_d;
            ongoru_q <= ongoru_d;
            yanlis_q <= yanlis_d;
            bos_q    <= bos_d;
        end
    end

    // NOTE: the counter table is reset because weak not-taken is its architectural start value;
    // the queue payload below is not, since cnt_q alone decides which slots hold live entries.
    always_ff @(posedge i_saat) begin
        if (i_reset) begin
            for (int i = 0; i < TBL_D; i++) begin
                ctr_q[i] <= CTR_INIT;
            end
        end else if (pop) begin
            ctr_q[head_idx] <= ctr_new;
        end
    end

    always_ff @(posedge i_saat) begin
        if (push) begin
            pend_idx_q[tail_q]   <= req_idx;
            pend_guess_q[tail_q] <= req_guess;
        end
    end

    assign o_istek_hazir   = istek_hazir;
    assign o_tahmin_hazir  = hazir_q;
    assign o_buyruk_ongoru = ongoru_q;
    assign o_ongoru_yanlis = yanlis_q;
    assign o_bos_cozum     = bos_q;
    assign o_gecmis        = hist_q;
    assign o_bekleyen      = cnt_q;

endmodule

// File: tb/tb_gshare_ongorucu_param.sv
// Scoreboard bench for gshare_ongorucu_param: stimulus pushes expected guesses and mispredict
// pulses into queues, a monitor pops and compares whenever the DUT presents them.
module tb_gshare_ongorucu_param;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_tahmin_gecerli = 1'b0;
    logic [31:0] i_buyruk_sayaci = '0;
    logic        i_sonuc_gecerli = 1'b0;
    logic        i_buyruk_atladi = 1'b0;
    logic        o_istek_hazir;
    logic        o_tahmin_hazir;
    logic        o_buyruk_ongoru;
    logic        o_ongoru_yanlis;
    logic        o_bos_cozum;
    logic [4:0]  o_gecmis;
    logic [2:0]  o_bekleyen;

    int n_checks = 0;
    int n_pass   = 0;

    logic exp_pred[$];
    logic exp_mis[$];

    gshare_ongorucu_param #(
        .IDX_W(5), .HIST_W(5), .CTR_W(2), .PC_LSB(2), .PEND_DEPTH(4)
    ) dut (
        .i_saat           (clk),
        .i_reset          (i_reset),
        .i_tahmin_gecerli (i_tahmin_gecerli),
        .i_buyruk_sayaci  (i_buyruk_sayaci),
        .o_istek_hazir    (o_istek_hazir),
        .o_tahmin_hazir   (o_tahmin_hazir),
        .o_buyruk_ongoru  (o_buyruk_ongoru),
        .i_sonuc_gecerli  (i_sonuc_gecerli),
        .i_buyruk_atladi  (i_buyruk_atladi),
        .o_ongoru_yanlis  (o_ongoru_yanlis),
        .o_bos_cozum      (o_bos_cozum),
        .o_gecmis         (o_gecmis),
        .o_bekleyen       (o_bekleyen)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, let the DUT clock them, and return at the following negedge.
    task automatic tick(input logic pv, input logic [31:0] pc, input logic rv, input logic tk,
                        input logic rst);
        i_tahmin_gecerli = pv;
        i_buyruk_sayaci  = pc;
        i_sonuc_gecerli  = rv;
        i_buyruk_atladi  = tk;
        i_reset          = rst;
        @(negedge clk);
        i_tahmin_gecerli = 1'b0;
        i_sonuc_gecerli  = 1'b0;
        i_buyruk_atladi  = 1'b0;
        i_reset          = 1'b0;
    endtask

    task automatic predict(input logic [31:0] pc, input logic guess);
        exp_pred.push_back(guess);
        tick(1'b1, pc, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic resolve(input logic taken, input logic mis);
        if (mis) exp_mis.push_back(1'b1);
        tick(1'b0, 32'h0, 1'b1, taken, 1'b0);
    endtask

    // Monitor: compares every presented prediction and every mispredict pulse.
    initial begin
        logic e;
        forever begin
            @(negedge clk);
            if (o_tahmin_hazir) begin
                if (exp_pred.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_pred: got tahmin_hazir=1, expected none at %0t", $time);
                end else begin
                    e = exp_pred.pop_front();
                    check("pred_guess", {31'b0, o_buyruk_ongoru}, {31'b0, e});
                end
            end
            if (o_ongoru_yanlis) begin
                if (exp_mis.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_mispredict: got ongoru_yanlis=1, expected 0 at %0t", $time);
                end else begin
                    e = exp_mis.pop_front();
                    check("mispredict_pulse", 32'(o_ongoru_yanlis), 32'(e));
                end
            end
        end
    end

    initial begin
        // Reset state
        tick(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        check("rst_istek_hazir", 32'(o_istek_hazir), 32'd1);
        check("rst_tahmin_hazir", 32'(o_tahmin_hazir), 32'd0);
        check("rst_ongoru", 32'(o_buyruk_ongoru), 32'd0);
        check("rst_yanlis", 32'(o_ongoru_yanlis), 32'd0);
        check("rst_bos", 32'(o_bos_cozum), 32'd0);
        check("rst_gecmis", 32'(o_gecmis), 32'd0);
        check("rst_bekleyen", 32'(o_bekleyen), 32'd0);

        // 1: PC 0x40 -> idx 16, weak NT
        predict(32'h40, 1'b0);
        check("t1_bekleyen", 32'(o_bekleyen), 32'd1);
        resolve(1'b0, 1'b0);
        check("t1_gecmis", 32'(o_gecmis), 32'd0);
        check("t1_yanlis", 32'(o_ongoru_yanlis), 32'd0);

        // Drive history to all ones with five taken branches at idx 0,1,3,7,15
        for (int i = 0; i < 5; i++) begin
            predict(32'h0, 1'b0);
            resolve(1'b1, 1'b1);
        end
        check("hist_ones", 32'(o_gecmis), 32'h1f);

        // 2: PC 0x80 with history 31 -> idx 31; 1->2 (mispredict), 2->3, 3 sat, 3 sat
        predict(32'h80, 1'b0);
        resolve(1'b1, 1'b1);
        predict(32'h80, 1'b1);
        resolve(1'b1, 1'b0);
        predict(32'h80, 1'b1);
        resolve(1'b1, 1'b0);
        predict(32'h80, 1'b1);
        resolve(1'b1, 1'b0);
        predict(32'h80, 1'b1);
        resolve(1'b1, 1'b0);
        check("t2_ongoru_hold", 32'(o_buyruk_ongoru), 32'd1);
        check("t2_bekleyen", 32'(o_bekleyen), 32'd0);

        // 3: fill the queue: idx 30, 29, 28 (weak NT) and 31 (strong T)
        predict(32'h84, 1'b0);
        predict(32'h88, 1'b0);
        predict(32'h8c, 1'b0);
        predict(32'h80, 1'b1);
        check("t3_full_hazir", 32'(o_istek_hazir), 32'd0);
        check("t3_full_bekleyen", 32'(o_bekleyen), 32'd4);
        tick(1'b1, 32'h80, 1'b0, 1'b0, 1'b0);
        check("t3_ignored_bekleyen", 32'(o_bekleyen), 32'd4);

        // Correct pop while full: same-cycle request must still be refused
        tick(1'b1, 32'h80, 1'b1, 1'b0, 1'b0);
        check("t3_pop_full_bekleyen", 32'(o_bekleyen), 32'd3);
        check("t3_pop_full_gecmis", 32'(o_gecmis), 32'h1e);

        // 4: head guess 0 resolves taken with a same-cycle request -> flush, request dropped
        exp_mis.push_back(1'b1);
        tick(1'b1, 32'h84, 1'b1, 1'b1, 1'b0);
        check("t4_yanlis", 32'(o_ongoru_yanlis), 32'd1);
        check("t4_bekleyen", 32'(o_bekleyen), 32'd0);
        check("t4_gecmis", 32'(o_gecmis), 32'h1d);
        check("t4_no_pred", 32'(o_tahmin_hazir), 32'd0);
        tick(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("t4_yanlis_pulse_end", 32'(o_ongoru_yanlis), 32'd0);

        // 5: resolve with an empty queue
        resolve(1'b1, 1'b0);
        check("t5_bos", 32'(o_bos_cozum), 32'd1);
        check("t5_gecmis", 32'(o_gecmis), 32'h1d);
        check("t5_yanlis", 32'(o_ongoru_yanlis), 32'd0);
        tick(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("t5_bos_sticky", 32'(o_bos_cozum), 32'd1);

        // Simultaneous push and correct pop: idx 29 (ctr 2) then idx 28 under history 29
        predict(32'h80, 1'b1);
        exp_pred.push_back(1'b0);
        tick(1'b1, 32'h84, 1'b1, 1'b1, 1'b0);
        check("pp_bekleyen", 32'(o_bekleyen), 32'd1);
        check("pp_gecmis", 32'(o_gecmis), 32'h1b);
        resolve(1'b0, 1'b0);
        check("pp_drain_gecmis", 32'(o_gecmis), 32'h16);
        check("pp_drain_bekleyen", 32'(o_bekleyen), 32'd0);

        // 6: two pending, then reset with request and resolve active
        predict(32'h80, 1'b0);
        predict(32'h84, 1'b0);
        check("t6_bekleyen_pre", 32'(o_bekleyen), 32'd2);
        tick(1'b1, 32'h88, 1'b1, 1'b1, 1'b1);
        check("t6_bekleyen", 32'(o_bekleyen), 32'd0);
        check("t6_no_pred", 32'(o_tahmin_hazir), 32'd0);
        check("t6_gecmis", 32'(o_gecmis), 32'd0);
        check("t6_bos", 32'(o_bos_cozum), 32'd0);
        check("t6_istek_hazir", 32'(o_istek_hazir), 32'd1);
        // Counters that had been trained (idx 0, 31, 15) are back to weak not-taken
        predict(32'h00, 1'b0);
        predict(32'h7c, 1'b0);
        predict(32'h3c, 1'b0);
        check("t6_bekleyen_post", 32'(o_bekleyen), 32'd3);

        tick(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("pred_queue_drained", 32'(exp_pred.size()), 32'd0);
        check("mis_queue_drained", 32'(exp_mis.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
